// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer_if
// Brief    : Producer-side word handshake and serial output bundle for
//            bit_serializer.
// Revision : 1.0
// ============================================================================
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             xv;
    logic             done;

    modport master (output din, load, input ready, x, xv, done);
    modport slave  (input din, load, output ready, x, xv, done);
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Brief    : MSB-first parallel-to-serial converter with a one-cycle done pulse.
//            Define PARITY_EN to append an even-parity slot after the LSB.
// Revision : 1.0
// ============================================================================
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input wire              clk,
    input wire              reset,
    bit_serializer_if.slave bus
);

    localparam int                c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]   c_CNT_LOAD = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PARITY_EN
        ,PARITY = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
`ifdef PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
`ifdef PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
`ifdef PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            IDLE: begin
                // ready is high only in IDLE, so load is honoured only here
                if (bus.load) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = bus.din;
                    w_cnt_nxt   = c_CNT_LOAD;
`ifdef PARITY_EN
                    w_par_nxt   = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                w_cnt_nxt   = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
`ifdef PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no path from load or din.
    always_comb begin
        bus.ready = (r_state == IDLE);
        bus.xv    = (r_state != IDLE);
        bus.done  = r_done;
        bus.x     = 1'b0;
        if (r_state == SHIFT) begin
            bus.x = r_shreg[WIDTH-1];
        end
`ifdef PARITY_EN
        if (r_state == PARITY) begin
            bus.x = r_par;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Brief    : Directed and random stimulus for bit_serializer against a
//            slot-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_bit_serializer;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    // Expected output stream: one entry per remaining valid slot of the word.
    logic q_slots[$];
    logic m_done;

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, ".x"},     {31'd0, bus.x},     32'd0);
        check({tag, ".xv"},    {31'd0, bus.xv},    32'd0);
        check({tag, ".ready"}, {31'd0, bus.ready}, 32'd1);
        check({tag, ".done"},  {31'd0, bus.done},  32'd0);
    endtask

    // Checks this cycle's outputs against the model, then presents new
    // inputs for the next rising edge and advances the model accordingly.
    task automatic cycle(input logic ld, input logic [WIDTH-1:0] d);
        logic             busy;
        logic [WIDTH-1:0] word;
        @(negedge clk);
        busy = (q_slots.size() != 0);
        check("xv",    {31'd0, bus.xv},    {31'd0, busy});
        check("x",     {31'd0, bus.x},     {31'd0, busy ? q_slots[0] : 1'b0});
        check("ready", {31'd0, bus.ready}, {31'd0, !busy});
        check("done",  {31'd0, bus.done},  {31'd0, !busy && m_done});
        bus.load = ld;
        bus.din  = d;
        if (busy) begin
            void'(q_slots.pop_front());
            m_done = (q_slots.size() == 0);
        end else begin
            m_done = 1'b0;
            if (ld) begin
                word = d;
                for (int i = WIDTH - 1; i >= 0; i--) q_slots.push_back(word[i]);
`ifdef PARITY_EN
                q_slots.push_back(^word);
`endif
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        m_done   = 1'b0;
        reset    = 1'b0;
        bus.load = 1'b0;
        bus.din  = '0;

        repeat (2) @(negedge clk);
        check_idle_now("reset");
        // A load during reset must not be captured.
        bus.load = 1'b1;
        bus.din  = 8'hFF;
        @(negedge clk);
        check_idle_now("reset_load");
        bus.load = 1'b0;
        #2 reset = 1'b1;

        // Basic word, then the parity-contrast word.
        cycle(1'b1, 8'hA5);
        idle_cycles(WIDTH + 4);
        cycle(1'b1, 8'h07);
        idle_cycles(WIDTH + 4);

        // Back-to-back with load held high.
        cycle(1'b1, 8'hFF);
        for (int i = 0; i < WIDTH + 1; i++) cycle(1'b1, 8'h00);
        idle_cycles(WIDTH + 4);

        // Load pulsed while busy must be ignored; din wiggles mid-word.
        cycle(1'b1, 8'hA5);
        idle_cycles(2);
        cycle(1'b1, 8'h3C);
        for (int i = 0; i < WIDTH; i++) cycle(1'b0, WIDTH'($urandom));
        idle_cycles(2);

        // Asynchronous reset mid-word, away from the clock edge.
        cycle(1'b1, 8'hA5);
        idle_cycles(4);
        #2 reset = 1'b0;
        #1 check_idle_now("async_rst");
        q_slots.delete();
        m_done = 1'b0;
        #1 reset = 1'b1;
        idle_cycles(WIDTH + 2);
        cycle(1'b1, 8'h81);
        idle_cycles(WIDTH + 3);

        // Boundary words.
        cycle(1'b1, 8'h00);
        idle_cycles(WIDTH + 2);
        cycle(1'b1, 8'h80);
        idle_cycles(WIDTH + 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end
        idle_cycles(WIDTH + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
